chrisruk_scroll_sched: RTL and testbench
========================================

// Module: chrisruk_scroll_sched
// PURPOSE
//   Frame scheduler for the 8x8 LED-matrix scroll renderer. Buffers incoming digit codes in a small FIFO.
//   Paces frame starts and hands the renderer one {cur digit, next digit, shift, blank flags} job per frame
//   via a req/ack/done handshake. Advances shift 0..7 and rotates digits on wrap.
//   Sits between the io_in pin/decoder logic and the renderer that drives io_out[1:0].
// PARAMETERS
//   DIGIT_W    1     width of a digit code (font index)
//   FIFO_DEPTH 4     digit FIFO entries (power of 2, >=2)
//   FRAME_GAP  32    idle clk cycles between renderer done and next request (>=1)
//   TIMEOUT    8192  max clk cycles in BUSY before forced advance (>= one full frame)
// PORTS
//   clk          in   1        single clock, all state on posedge
//   reset        in   1        asynchronous, active-high; clears all state immediately
//   digit_valid  in   1        push request for digit_in
//   digit_in     in   DIGIT_W  digit code to enqueue
//   digit_ready  out  1        FIFO not full; push occurs when valid & ready
//   pause        in   1        level; stop issuing new frames (current frame completes)
//   frame_req    out  1        job valid; held until frame_ack
//   frame_ack    in   1        renderer accepted job (1-cycle pulse or level)
//   frame_done   in   1        renderer finished frame (1-cycle pulse)
//   cur_digit    out  DIGIT_W  outgoing (left) digit code, stable while req|BUSY
//   next_digit   out  DIGIT_W  incoming (right) digit code
//   shift        out  3        scroll offset 0..7
//   blank_cur    out  1        render cur_digit as all-off
//   blank_next   out  1        render next_digit as all-off
//   timeout_err  out  1        sticky: a frame timed out; cleared only by reset
// BEHAVIOUR
//   Reset values: digit_ready=1, frame_req=0, cur/next_digit=0, shift=0, blank_cur=1, blank_next=1,
//     timeout_err=0, FIFO empty, gap counter=0, state=GAP.
//   FSM states: GAP, REQ, BUSY, ADV.
//   GAP:
//     - count up each cycle; when count==FRAME_GAP-1 and !pause -> REQ, count cleared.
//     - pause holds the count at its terminal value.
//   REQ:
//     - frame_req=1; job outputs frozen.
//     - frame_ack -> BUSY next cycle, frame_req drops same edge.
//     - frame_done without prior ack is ignored.
//   BUSY:
//     - frame_done -> ADV.
//     - If the TIMEOUT cycle counter expires first: set timeout_err, -> ADV.
//     - frame_done and expiry in same cycle: treat as done, no error.
//   ADV: single cycle, then GAP.
//     - shift<7: shift+1.
//     - shift==7: shift=0; cur_digit<=next_digit, blank_cur<=blank_next.
//         FIFO non-empty: pop head into next_digit, blank_next=0.
//         Else next_digit=0, blank_next=1 (blank scrolls in).
//   FIFO:
//     - digit_ready = !full (registered full flag, no pass-through).
//     - Simultaneous push and pop when full: pop only; push refused because ready=0.
//     - Simultaneous push and pop when empty: pop sees empty (blank); pushed word stored.
//     - Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
//   Latency: done -> next frame_req = 1 (ADV) + FRAME_GAP cycles.
//   Reset mid-frame: outputs return to reset values asynchronously; renderer must also be reset.
//     No job resumes.
//   Widths: counters sized by clog2 of parameter; shift wraps 7->0 only in ADV.
// STRUCTURE
//   Package matrix_pkg:
//     - state encoding localparams (GAP/REQ/BUSY/ADV)
//     - SHIFT_W=3
//     - MATRIX_DIM=8
//     - clog2 helper function
//   Sub-module matrix_digit_fifo:
//     - synchronous FIFO with push/pop/full/empty/head, async reset
//   Top: FSM, gap/timeout counters, job registers.
// TESTING
//   1 Reset, no pushes, FRAME_GAP=4: frame_req rises at cycle 4; 8 ack/done frames give shift 0..7 then 0.
//     blank_cur=blank_next=1 throughout.
//   2 Push 1 then 0 before first wrap: after 8th done, cur=0 blank_cur=1, next=1 blank_next=0.
//     After 16th done, cur=1 blank_cur=0, next=0 blank_next=0.
//   3 Push 5 words, DEPTH=4: 5th sees digit_ready=0, not stored.
//     Push at full with wrap pop in the same cycle: only pop occurs.
//   4 Ack, withhold frame_done, TIMEOUT=64: timeout_err=1 at BUSY cycle 64, shift advances.
//     Further frames normal, error stays 1.
//   5 pause=1 during BUSY: done still advances shift; no frame_req while paused.
//     pause=0: frame_req on the next cycle.
//   6 Assert reset mid-BUSY, between clock edges: outputs reach reset values before the next edge.
//     After release, first frame_req after FRAME_GAP cycles.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and constants for the LED-matrix scroll scheduler: FSM state
// encoding, scroll geometry and a constant-width helper.
package matrix_pkg;

  localparam int SHIFT_W    = 3;
  localparam int MATRIX_DIM = 8;

  localparam logic [1:0] GAP_ENC  = 2'd0;
  localparam logic [1:0] REQ_ENC  = 2'd1;
  localparam logic [1:0] BUSY_ENC = 2'd2;
  localparam logic [1:0] ADV_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_GAP  = GAP_ENC,
    ST_REQ  = REQ_ENC,
    ST_BUSY = BUSY_ENC,
    ST_ADV  = ADV_ENC
  } state_t;

  // Bits needed to hold 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/matrix_digit_fifo.sv
// Small synchronous digit FIFO with a registered full flag so that the ready
// seen by the producer never depends combinationally on a same-cycle pop.
module matrix_digit_fifo
  import matrix_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             full_q;
  logic             push_ok;
  logic             pop_ok;

  // A pop on an empty FIFO is dropped even if a push lands in the same cycle.
  assign push_ok = push && !full_q;
  assign pop_ok  = pop && (count != '0);
  assign full    = full_q;
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) count_next = count + CNT_W'(1);
    else if (!push_ok && pop_ok) count_next = count - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count_next;
      full_q <= (count_next == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/chrisruk_scroll_sched.sv
// Frame scheduler for the 8x8 scroll renderer: paces frames, hands out one
// {cur, next, shift, blank} job per frame and rotates digits on shift wrap.
module chrisruk_scroll_sched
  import matrix_pkg::*;
#(
  parameter int DIGIT_W    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_GAP  = 32,
  parameter int TIMEOUT    = 8192
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit_in,
  output logic               digit_ready,
  input  logic               pause,
  output logic               frame_req,
  input  logic               frame_ack,
  input  logic               frame_done,
  output logic [DIGIT_W-1:0] cur_digit,
  output logic [DIGIT_W-1:0] next_digit,
  output logic [SHIFT_W-1:0] shift,
  output logic               blank_cur,
  output logic               blank_next,
  output logic               timeout_err
);

  localparam int GAP_W = clog2(FRAME_GAP);
  localparam int TMO_W = clog2(TIMEOUT);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(FRAME_GAP - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT - 1);
  localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(MATRIX_DIM - 1);

  state_t             state;
  state_t             state_next;
  logic [GAP_W-1:0]   gap_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               tmo_expire;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DIGIT_W-1:0] fifo_head;

  assign tmo_expire  = (tmo_cnt == TMO_LAST);
  assign fifo_pop    = (state == ST_ADV) && (shift == SHIFT_LAST);
  assign digit_ready = !fifo_full;

  matrix_digit_fifo #(
    .WIDTH (DIGIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (digit_valid),
    .push_data (digit_in),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_GAP;
    else       state <= state_next;
  end

  // A done arriving in the expiry cycle wins, so the frame is not flagged.
  always_comb begin
    state_next = state;
    case (state)
      ST_GAP:  if ((gap_cnt == GAP_LAST) && !pause) state_next = ST_REQ;
      ST_REQ:  if (frame_ack) state_next = ST_BUSY;
      ST_BUSY: if (frame_done || tmo_expire) state_next = ST_ADV;
      ST_ADV:  state_next = ST_GAP;
      default: state_next = ST_GAP;
    endcase
  end

  always_comb begin
    frame_req = 1'b0;
    if (state == ST_REQ) frame_req = 1'b1;
  end

  // Gap count parks at its terminal value while paused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt     <= '0;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ST_GAP) begin
        if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + GAP_W'(1);
        else if (!pause)         gap_cnt <= '0;
      end else begin
        gap_cnt <= '0;
      end
      tmo_cnt <= (state == ST_BUSY) ? tmo_cnt + TMO_W'(1) : '0;
      if ((state == ST_BUSY) && tmo_expire && !frame_done) timeout_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift      <= '0;
      cur_digit  <= '0;
      next_digit <= '0;
      blank_cur  <= 1'b1;
      blank_next <= 1'b1;
    end else if (state == ST_ADV) begin
      if (shift != SHIFT_LAST) begin
        shift <= shift + SHIFT_W'(1);
      end else begin
        shift     <= '0;
        cur_digit <= next_digit;
        blank_cur <= blank_next;
        if (!fifo_empty) begin
          next_digit <= fifo_head;
          blank_next <= 1'b0;
        end else begin
          next_digit <= '0;
          blank_next <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_chrisruk_scroll_sched.sv
// Self-checking bench for chrisruk_scroll_sched: directed scenarios plus random
// frames, scored against a frame-level model with a queue for the digit FIFO.
module tb_chrisruk_scroll_sched;

  localparam int DW    = 1;
  localparam int DEPTH = 4;
  localparam int GAP   = 4;
  localparam int TMO   = 64;
  localparam int LIMIT = 300;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          digit_valid = 1'b0;
  logic [DW-1:0] digit_in = '0;
  logic          digit_ready;
  logic          pause = 1'b0;
  logic          frame_req;
  logic          frame_ack = 1'b0;
  logic          frame_done = 1'b0;
  logic [DW-1:0] cur_digit;
  logic [DW-1:0] next_digit;
  logic [2:0]    shift;
  logic          blank_cur;
  logic          blank_next;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  int            m_shift;
  logic [DW-1:0] m_cur, m_next;
  logic          m_bc, m_bn, m_err;
  logic [DW-1:0] m_q[$];
  bit            adv_armed;
  int            push_mode;

  always #5 clk = ~clk;

  chrisruk_scroll_sched #(
    .DIGIT_W(DW), .FIFO_DEPTH(DEPTH), .FRAME_GAP(GAP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit_in(digit_in),
    .digit_ready(digit_ready), .pause(pause), .frame_req(frame_req),
    .frame_ack(frame_ack), .frame_done(frame_done), .cur_digit(cur_digit),
    .next_digit(next_digit), .shift(shift), .blank_cur(blank_cur),
    .blank_next(blank_next), .timeout_err(timeout_err)
  );

  function automatic void model_reset();
    m_shift = 0; m_cur = '0; m_next = '0; m_bc = 1'b1; m_bn = 1'b1; m_err = 1'b0;
    m_q.delete(); adv_armed = 0;
  endfunction

  // One frame completed: scroll one column, rotate digits after the last column.
  function automatic void model_advance();
    if (m_shift < 7) begin
      m_shift = m_shift + 1;
    end else begin
      m_shift = 0; m_cur = m_next; m_bc = m_bn;
      if (m_q.size() > 0) begin m_next = m_q.pop_front(); m_bn = 1'b0; end
      else begin m_next = '0; m_bn = 1'b1; end
    end
  endfunction

  task automatic tick();
    bit do_adv, do_push;
    logic exp_ready;
    logic [DW-1:0] pv;
    exp_ready = (m_q.size() < DEPTH);
    checks++;
    if (digit_ready !== exp_ready) begin
      errors++; $display("[TB] FAIL digit_ready: got %0b want %0b", digit_ready, exp_ready);
    end
    do_adv = adv_armed; adv_armed = 0;
    do_push = digit_valid && exp_ready; pv = digit_in;
    @(posedge clk);
    if (do_adv) model_advance();
    if (do_push) m_q.push_back(pv);
    #1;
    if (push_mode == 1) begin
      digit_valid = ($urandom_range(0, 3) == 0);
      digit_in = DW'($urandom_range(0, 1));
    end
  endtask

  task automatic check_job(input string tag);
    checks++; if (shift !== 3'(m_shift)) begin errors++; $display("[TB] FAIL %s shift: got %0d want %0d", tag, shift, m_shift); end
    checks++; if (cur_digit !== m_cur) begin errors++; $display("[TB] FAIL %s cur_digit: got %0d want %0d", tag, cur_digit, m_cur); end
    checks++; if (next_digit !== m_next) begin errors++; $display("[TB] FAIL %s next_digit: got %0d want %0d", tag, next_digit, m_next); end
    checks++; if (blank_cur !== m_bc) begin errors++; $display("[TB] FAIL %s blank_cur: got %0b want %0b", tag, blank_cur, m_bc); end
    checks++; if (blank_next !== m_bn) begin errors++; $display("[TB] FAIL %s blank_next: got %0b want %0b", tag, blank_next, m_bn); end
    checks++; if (timeout_err !== m_err) begin errors++; $display("[TB] FAIL %s timeout_err: got %0b want %0b", tag, timeout_err, m_err); end
  endtask

  task automatic do_reset();
    reset = 1'b1; digit_valid = 1'b0; digit_in = '0; pause = 1'b0;
    frame_ack = 1'b0; frame_done = 1'b0; push_mode = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_req(input int exp_lat);
    int n;
    n = 0;
    while (frame_req !== 1'b1 && n < LIMIT) begin tick(); n++; end
    checks++;
    if (frame_req !== 1'b1) begin
      errors++; $display("[TB] FAIL req_wait: got no frame_req after %0d cycles want 1", n);
    end else if (exp_lat >= 0) begin
      checks++;
      if (n != exp_lat) begin errors++; $display("[TB] FAIL req_latency: got %0d want %0d", n, exp_lat); end
    end
  endtask

  task automatic do_ack(input int dly, input bit spurious);
    for (int i = 0; i < dly; i++) begin
      if (spurious && i == 0) frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      checks++; if (frame_req !== 1'b1) begin errors++; $display("[TB] FAIL req_hold: got %0b want 1", frame_req); end
    end
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    checks++; if (frame_req !== 1'b0) begin errors++; $display("[TB] FAIL req_drop: got %0b want 0", frame_req); end
  endtask

  task automatic do_done(input int dly);
    for (int i = 0; i < dly; i++) tick();
    checks++; if (frame_req !== 1'b0) begin errors++; $display("[TB] FAIL busy_req: got %0b want 0", frame_req); end
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    adv_armed = 1;
    tick();
    check_job("adv");
  endtask

  task automatic run_frame(input int exp_lat, input int ack_d, input int done_d, input bit spur);
    wait_req(exp_lat);
    check_job("req");
    do_ack(ack_d, spur);
    do_done(done_d);
  endtask

  task automatic test_reset();
    do_reset();
    check_job("reset");
    checks++; if (frame_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %0b want 0", frame_req); end
    checks++; if (digit_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0b want 1", digit_ready); end
  endtask

  task automatic test_scroll_blank();
    for (int i = 0; i < 9; i++) begin
      run_frame(GAP, i % 2, i % 3, 1'b0);
      checks++; if (shift !== 3'((i + 1) % 8)) begin errors++; $display("[TB] FAIL scroll_shift: got %0d want %0d", shift, (i + 1) % 8); end
      checks++; if ({blank_cur, blank_next} !== 2'b11) begin errors++; $display("[TB] FAIL scroll_blank: got %b want 11", {blank_cur, blank_next}); end
    end
  endtask

  task automatic push_word(input logic [DW-1:0] v);
    digit_valid = 1'b1; digit_in = v;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic test_digit_rotate();
    do_reset();
    push_word(1'b1);
    push_word(1'b0);
    for (int i = 0; i < 16; i++) begin
      run_frame((i == 0) ? GAP - 2 : GAP, 0, 1, 1'b0);
      if (i == 7) begin
        checks++;
        if ({cur_digit, blank_cur, next_digit, blank_next} !== 4'b0110) begin
          errors++; $display("[TB] FAIL rotate8: got cur=%0d bc=%0b next=%0d bn=%0b want cur=0 bc=1 next=1 bn=0", cur_digit, blank_cur, next_digit, blank_next);
        end
      end
      if (i == 15) begin
        checks++;
        if ({cur_digit, blank_cur, next_digit, blank_next} !== 4'b1000) begin
          errors++; $display("[TB] FAIL rotate16: got cur=%0d bc=%0b next=%0d bn=%0b want cur=1 bc=0 next=0 bn=0", cur_digit, blank_cur, next_digit, blank_next);
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [DW-1:0] words [5];
    words = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        checks++; if (digit_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %0b want 0", digit_ready); end
      end
      push_word(words[i]);
    end
    digit_valid = 1'b1; digit_in = 1'b0; push_mode = 2;
    for (int i = 0; i < 8; i++) run_frame((i == 0) ? -1 : GAP, 1, 0, 1'b0);
    checks++; if (next_digit !== 1'b1 || blank_next !== 1'b0) begin errors++; $display("[TB] FAIL full_pop: got next=%0d bn=%0b want next=1 bn=0", next_digit, blank_next); end
    checks++; if (digit_ready !== 1'b1) begin errors++; $display("[TB] FAIL pop_ready: got %0b want 1", digit_ready); end
    tick();
    checks++; if (digit_ready !== 1'b0) begin errors++; $display("[TB] FAIL refill_ready: got %0b want 0", digit_ready); end
    digit_valid = 1'b0; push_mode = 0;
  endtask

  task automatic test_timeout();
    do_reset();
    wait_req(GAP);
    do_ack(0, 1'b0);
    for (int k = 1; k <= TMO; k++) begin
      tick();
      if (k == TMO - 1) begin
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL tmo_early: got %0b want 0", timeout_err); end
      end
    end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL tmo_set: got %0b want 1", timeout_err); end
    m_err = 1'b1;
    adv_armed = 1;
    tick();
    check_job("tmo_adv");
    for (int i = 0; i < 2; i++) run_frame(GAP, 0, 2, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    wait_req(GAP);
    do_ack(0, 1'b0);
    tick(); tick();
    reset = 1'b1;
    #2;
    model_reset();
    check_job("async_reset");
    checks++; if (frame_req !== 1'b0) begin errors++; $display("[TB] FAIL async_req: got %0b want 0", frame_req); end
    checks++; if (digit_ready !== 1'b1) begin errors++; $display("[TB] FAIL async_ready: got %0b want 1", digit_ready); end
    @(negedge clk);
    reset = 1'b0;
    run_frame(GAP, 0, 1, 1'b0);
  endtask

  task automatic test_pause();
    do_reset();
    wait_req(GAP);
    do_ack(1, 1'b0);
    pause = 1'b1;
    do_done(3);
    for (int i = 0; i < 3 * GAP; i++) begin
      tick();
      checks++; if (frame_req !== 1'b0) begin errors++; $display("[TB] FAIL pause_req: got %0b want 0", frame_req); end
    end
    checks++; if (shift !== 3'd1) begin errors++; $display("[TB] FAIL pause_shift: got %0d want 1", shift); end
    pause = 1'b0;
    tick();
    checks++; if (frame_req !== 1'b1) begin errors++; $display("[TB] FAIL unpause_req: got %0b want 1", frame_req); end
    run_frame(0, 0, 1, 1'b0);
  endtask

  task automatic test_random_frames();
    do_reset();
    push_mode = 1;
    for (int i = 0; i < 40; i++) begin
      run_frame(GAP, $urandom_range(0, 3), $urandom_range(0, 10), 1'($urandom_range(0, 1)));
    end
    push_mode = 0; digit_valid = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_scroll_blank();
    test_digit_rotate();
    test_fifo_full();
    test_timeout();
    test_reset_mid_frame();
    test_pause();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
